// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor, one bit per clock, LSB first
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic op_q, op_d, carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic bx, sum, cell_c, accept, last;
  always_comb begin
    bx       = b_q[0] ^ op_q;
    sum      = a_q[0] ^ bx ^ carry_q;
    cell_c   = (a_q[0] & bx) | (a_q[0] & carry_q) | (bx & carry_q);
    accept   = start && state_q != RUN;
    last     = state_q == RUN && cnt_q == CW'(WIDTH - 1);
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    if (accept) begin
      state_d  = RUN;
      a_d      = a;
      b_d      = b;
      op_d     = op;
      carry_d  = op;
      cnt_d    = '0;
      result_d = '0;
      cout_d   = 1'b0;
      ovf_d    = 1'b0;
    end else if (state_q == RUN) begin
      result_d = {sum, result_q[WIDTH-1:1]};
      a_d      = a_q >> 1;
      b_d      = b_q >> 1;
      carry_d  = cell_c;
      cnt_d    = last ? cnt_q : cnt_q + 1'b1;
      cout_d   = last ? cell_c : cout_q;
      ovf_d    = last ? carry_q ^ cell_c : ovf_q;
      state_d  = last ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d  = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end
  assign busy     = state_q == RUN;
  assign done     = state_q == DONE;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and random checks of serial_addsub against an arithmetic model
module tb_serial_addsub;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, op = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, cout, overflow;
  logic [W-1:0] result;
  int n_cmp = 0, n_err = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                                output logic [W-1:0] r, output logic c, output logic v);
    int s, sr;
    s  = int'(x) + (o ? ((1 << W) - int'(y)) : int'(y));
    r  = W'(s);
    c  = s >= (1 << W);
    sr = o ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
    v  = sr > (1 << (W - 1)) - 1 || sr < -(1 << (W - 1));
  endfunction

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
    logic [W-1:0] er;
    logic ec, ev;
    model(x, y, o, er, ec, ev);
    @(posedge clk); #1;
    start = 1'b1; a = x; b = y; op = o;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); op = 1'($urandom);
    chk("busy_after_e0", {busy, done}, 2'b10);
    for (int k = 1; k < W; k++) begin
      @(posedge clk); #1;
      chk("busy_run", {busy, done}, 2'b10);
    end
    @(posedge clk); #1;
    chk("done_at_ew", {busy, done}, 2'b01);
    chk("result", result, er);
    chk("cout", cout, ec);
    chk("overflow", overflow, ev);
    @(posedge clk); #1;
    chk("done_single", {busy, done}, 2'b00);
    chk("hold", {result, cout, overflow}, {er, ec, ev});
  endtask

  initial begin
    #2;
    chk("reset_outputs", {busy, done, result, cout, overflow}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // directed arithmetic cases
    do_op(8'd100, 8'd27, 1'b0);
    chk("t1_result_const", result, 32'd127);
    do_op(8'd5, 8'd7, 1'b1);
    chk("t2_sub_neg", {result, cout, overflow}, {8'hFE, 1'b0, 1'b0});
    do_op(8'd7, 8'd5, 1'b1);
    chk("t2_sub_pos", {result, cout}, {8'h02, 1'b1});
    do_op(8'h7F, 8'h01, 1'b0);
    chk("t3_add_ovf", {result, cout, overflow}, {8'h80, 1'b0, 1'b1});
    do_op(8'h80, 8'h01, 1'b1);
    chk("t3_sub_ovf", {result, cout, overflow}, {8'h7F, 1'b1, 1'b1});
    do_op(8'h00, 8'h00, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b0);
    // start during RUN is ignored
    @(posedge clk); #1;
    start = 1'b1; a = 8'd1; b = 8'd1; op = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < W; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; op = 1'b1;
      end else start = 1'b0;
      chk("t4_busy", {busy, done}, 2'b10);
    end
    @(posedge clk); #1;
    chk("t4_done", {busy, done, result}, {2'b01, 8'd2});
    @(posedge clk); #1;
    chk("t4_single_done", {busy, done}, 2'b00);
    // asynchronous reset mid-operation
    @(posedge clk); #1;
    start = 1'b1; a = 8'hAA; b = 8'h55; op = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_reset", {busy, done, result, cout, overflow}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'd3, 8'd4, 1'b0);
    chk("t5_after_reset", result, 32'd7);
    // continuous start: one result every W+1 cycles
    @(posedge clk); #1;
    start = 1'b1; a = 8'd10; b = 8'd20; op = 1'b0;
    for (int t = 0; t < 3 * (W + 1); t++) begin
      @(posedge clk); #1;
      chk("t6_pattern", {busy, done}, (t % (W + 1) == W) ? 2'b01 : 2'b10);
      if (t % (W + 1) == W) chk("t6_result", result, 32'd30);
    end
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_idle", {busy, done}, 2'b00);
    // random operations
    for (int i = 0; i < 40; i++) do_op(W'($urandom), W'($urandom), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
